// File: rtl/pcap_replay_pkg.sv
// rtl/pcap_replay_pkg.sv - shared types and sizing helpers for the pcap replay scheduler
package pcap_replay_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN,
        ST_GAP,
        ST_DONE
    } state_e;

    localparam int DEF_MAX_OUTSTANDING = 8;

    // One extra bit so the counter can hold MAX_OUTSTANDING itself.
    function automatic int credit_width(input int max_outstanding);
        return $clog2(max_outstanding) + 1;
    endfunction

    localparam int CREDIT_W = credit_width(DEF_MAX_OUTSTANDING);

endpackage

// File: rtl/pcap_replay_sched_if.sv
// rtl/pcap_replay_sched_if.sv - read request / read return channel between scheduler and QDR reader
interface pcap_replay_sched_if #(
    parameter int ADDR_WIDTH = 19
);
    logic                  rd_req_valid;
    logic [ADDR_WIDTH-1:0] rd_req_addr;
    logic                  rd_req_ready;
    logic                  rd_data_valid;

    modport master (
        output rd_req_valid,
        output rd_req_addr,
        input  rd_req_ready,
        input  rd_data_valid
    );

    modport slave (
        input  rd_req_valid,
        input  rd_req_addr,
        output rd_req_ready,
        output rd_data_valid
    );
endinterface

// File: rtl/pcap_replay_credit.sv
// rtl/pcap_replay_credit.sv - in-flight read credit counter
// full_o/empty_o describe the count after this cycle's events so the scheduler can register decisions.
module pcap_replay_credit
    import pcap_replay_pkg::*;
#(
    parameter int MAX_OUTSTANDING = DEF_MAX_OUTSTANDING,
    parameter int CW              = credit_width(MAX_OUTSTANDING)
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic inc_i,
    input  logic dec_i,
    output logic full_o,
    output logic empty_o,
    output logic underflow_o
);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          dec_ok;

    always_comb begin
        dec_ok = dec_i && (cnt_q != '0);
        cnt_d  = cnt_q;
        if (inc_i && !dec_ok) begin
            cnt_d = cnt_q + CW'(1);
        end else if (!inc_i && dec_ok) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign full_o      = (cnt_d == MAX_CNT);
    assign empty_o     = (cnt_d == '0);
    assign underflow_o = dec_i && (cnt_q == '0);

endmodule

// File: rtl/pcap_replay_sched.sv
// rtl/pcap_replay_sched.sv - replay scheduler: loops word reads over the captured QDR region
// Optional inter-iteration gap enabled by defining PCAP_REPLAY_IPG_EN (adds iter_gap input).
module pcap_replay_sched
    import pcap_replay_pkg::*;
#(
    parameter int ADDR_WIDTH      = 19,
    parameter int CNT_WIDTH       = 32,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                   axi_aclk,
    input  logic                   axi_reset,
    input  logic                   replay_en,
    input  logic [CNT_WIDTH-1:0]   replay_iter,
`ifdef PCAP_REPLAY_IPG_EN
    input  logic [CNT_WIDTH-1:0]   iter_gap,
`endif
    input  logic [ADDR_WIDTH-1:0]  mem_base_addr,
    input  logic [ADDR_WIDTH-1:0]  wr_last_addr,
    input  logic                   wr_last_vld,
    pcap_replay_sched_if.master    rd,
    output logic                   busy,
    output logic                   replay_done,
    output logic [CNT_WIDTH-1:0]   iter_done_cnt,
    output logic                   cfg_err
);
    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d, base_q, base_d, last_q, last_d;
    logic [CNT_WIDTH-1:0]  iter_q, iter_d, cnt_q, cnt_d, cnt_inc;
    logic                  valid_q, valid_d, abort_q, abort_d;
    logic                  done_q, done_d, err_q, err_d;
`ifdef PCAP_REPLAY_IPG_EN
    logic [CNT_WIDTH-1:0]  gap_q, gap_d, gap_cnt_q, gap_cnt_d;
`endif
    logic                  hs, cred_full, cred_empty, cred_uf, cfg_ok, cfg_bad;

    assign hs      = valid_q && rd.rd_req_ready;
    assign cfg_ok  = replay_en && wr_last_vld && (wr_last_addr >= mem_base_addr);
    assign cfg_bad = replay_en && wr_last_vld && (wr_last_addr < mem_base_addr);
    assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_WIDTH'(1);

    pcap_replay_credit #(
        .MAX_OUTSTANDING (MAX_OUTSTANDING)
    ) u_credit (
        .clk_i       (axi_aclk),
        .rst_i       (axi_reset),
        .inc_i       (hs),
        .dec_i       (rd.rd_data_valid),
        .full_o      (cred_full),
        .empty_o     (cred_empty),
        .underflow_o (cred_uf)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        base_d  = base_q;
        last_d  = last_q;
        iter_d  = iter_q;
        cnt_d   = cnt_q;
        abort_d = abort_q;
        done_d  = 1'b0;
        err_d   = err_q | cred_uf;
        // A presented request is never retracted; it only drops on acceptance.
        valid_d = valid_q && !rd.rd_req_ready;
`ifdef PCAP_REPLAY_IPG_EN
        gap_d     = gap_q;
        gap_cnt_d = gap_cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (cfg_ok) begin
                    base_d  = mem_base_addr;
                    last_d  = wr_last_addr;
                    iter_d  = replay_iter;
                    addr_d  = mem_base_addr;
                    cnt_d   = '0;
                    abort_d = 1'b0;
                    valid_d = 1'b1;
                    state_d = ST_ISSUE;
`ifdef PCAP_REPLAY_IPG_EN
                    gap_d   = iter_gap;
`endif
                end else if (cfg_bad) begin
                    err_d = 1'b1;
                end
            end
            ST_ISSUE: begin
                if (hs && (addr_q == last_q)) begin
                    valid_d = 1'b0;
                    state_d = ST_DRAIN;
                end else if (!valid_q || hs) begin
                    if (!replay_en) begin
                        valid_d = 1'b0;
                        abort_d = 1'b1;
                        state_d = ST_DRAIN;
                    end else begin
                        if (hs) begin
                            addr_d = addr_q + ADDR_WIDTH'(1);
                        end
                        valid_d = !cred_full;
                    end
                end
            end
            ST_DRAIN: begin
                if (cred_empty) begin
                    if (abort_q) begin
                        abort_d = 1'b0;
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_inc;
                        if ((iter_q != '0) && (cnt_inc == iter_q)) begin
                            done_d  = 1'b1;
                            state_d = ST_DONE;
                        end else if (!replay_en) begin
                            state_d = ST_IDLE;
                        end else begin
                            addr_d = base_q;
`ifdef PCAP_REPLAY_IPG_EN
                            if (gap_q != '0) begin
                                gap_cnt_d = gap_q;
                                state_d   = ST_GAP;
                            end else begin
                                valid_d = 1'b1;
                                state_d = ST_ISSUE;
                            end
`else
                            valid_d = 1'b1;
                            state_d = ST_ISSUE;
`endif
                        end
                    end
                end
            end
`ifdef PCAP_REPLAY_IPG_EN
            ST_GAP: begin
                if (!replay_en) begin
                    state_d = ST_IDLE;
                end else if (gap_cnt_q == CNT_WIDTH'(1)) begin
                    valid_d = 1'b1;
                    state_d = ST_ISSUE;
                end else begin
                    gap_cnt_d = gap_cnt_q - CNT_WIDTH'(1);
                end
            end
`endif
            ST_DONE: begin
                if (!replay_en) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge axi_aclk) begin
        if (axi_reset) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            base_q    <= '0;
            last_q    <= '0;
            iter_q    <= '0;
            cnt_q     <= '0;
            valid_q   <= 1'b0;
            abort_q   <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
`ifdef PCAP_REPLAY_IPG_EN
            gap_q     <= '0;
            gap_cnt_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            base_q    <= base_d;
            last_q    <= last_d;
            iter_q    <= iter_d;
            cnt_q     <= cnt_d;
            valid_q   <= valid_d;
            abort_q   <= abort_d;
            done_q    <= done_d;
            err_q     <= err_d;
`ifdef PCAP_REPLAY_IPG_EN
            gap_q     <= gap_d;
            gap_cnt_q <= gap_cnt_d;
`endif
        end
    end

    assign rd.rd_req_valid = valid_q;
    assign rd.rd_req_addr  = addr_q;
    assign busy            = (state_q != ST_IDLE);
    assign replay_done     = done_q;
    assign iter_done_cnt   = cnt_q;
    assign cfg_err         = err_q;

endmodule

// File: tb/tb_pcap_replay_sched.sv
// tb/tb_pcap_replay_sched.sv - scoreboard bench for pcap_replay_sched (request addresses checked by monitor)
`timescale 1ns/1ps
module tb_pcap_replay_sched;
    localparam int AW = 19;
    localparam int CW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en = 1'b0;
    logic          vld = 1'b0;
    logic [CW-1:0] iter = '0;
    logic [AW-1:0] base = '0;
    logic [AW-1:0] wlast = '0;
`ifdef PCAP_REPLAY_IPG_EN
    logic [CW-1:0] gap = '0;
`endif
    logic          busy, done, cerr;
    logic [CW-1:0] icnt;
    logic          ready = 1'b0;
    logic          man_dv = 1'b0;
    logic          auto_ret = 1'b0;
    logic          dv_auto = 1'b0;
    logic          p0 = 1'b0, p1 = 1'b0, dv_new;

    int n_checks = 0;
    int n_errors = 0;
    int hs_cnt = 0;
    int done_pulses = 0;
    int cyc = 0;
    int rets = 0;
    int t_ret = -1;
    int t_req = -1;
    int h0;
    logic [AW-1:0] exp_q[$];
    logic [AW-1:0] exp_a;
    logic [CW-1:0] cnt_log[$];
    logic [CW-1:0] last_icnt = '0;

    pcap_replay_sched_if #(.ADDR_WIDTH(AW)) rif ();
    assign rif.rd_req_ready  = ready;
    assign rif.rd_data_valid = dv_auto | man_dv;

    pcap_replay_sched #(
        .ADDR_WIDTH      (AW),
        .CNT_WIDTH       (CW),
        .MAX_OUTSTANDING (8)
    ) dut (
        .axi_aclk      (clk),
        .axi_reset     (rst),
        .replay_en     (en),
        .replay_iter   (iter),
`ifdef PCAP_REPLAY_IPG_EN
        .iter_gap      (gap),
`endif
        .mem_base_addr (base),
        .wr_last_addr  (wlast),
        .wr_last_vld   (vld),
        .rd            (rif),
        .busy          (busy),
        .replay_done   (done),
        .iter_done_cnt (icnt),
        .cfg_err       (cerr)
    );

    always #5 clk = ~clk;

    // Monitor: pops expected addresses on each handshake, models a 2-cycle read return.
    always @(negedge clk) begin
        cyc++;
        if (rif.rd_req_valid && ready && !rst) begin
            hs_cnt++;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL req_addr: got %0h expected no request", rif.rd_req_addr);
            end else begin
                exp_a = exp_q.pop_front();
                if (rif.rd_req_addr !== exp_a) begin
                    n_errors++;
                    $display("FAIL req_addr: got %0h expected %0h", rif.rd_req_addr, exp_a);
                end
            end
        end
        dv_new  = (p1 & auto_ret) | man_dv;
        dv_auto = p1 & auto_ret;
        p1      = p0;
        p0      = rif.rd_req_valid && ready && !rst;
        if (dv_new) begin
            rets++;
            if (rets == 2) t_ret = cyc;
        end
        if (rif.rd_req_valid && (rets >= 2) && (t_req < 0)) t_req = cyc;
        if (done) done_pulses++;
        if (icnt != last_icnt) begin
            cnt_log.push_back(icnt);
            last_icnt = icnt;
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        en  = 1'b0;
        step(2);
        rst = 1'b0;
        step(1);
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (done_pulses == 0 && n < budget) begin
            step(1);
            n++;
        end
        check("done_timeout", 64'(done_pulses != 0), 1);
    endtask

    initial begin
        // Reset state
        step(3);
        check("rst_valid", rif.rd_req_valid, 0);
        check("rst_addr", rif.rd_req_addr, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_icnt", icnt, 0);
        check("rst_cerr", cerr, 0);
        rst = 1'b0;
        step(1);

        // Two iterations over 0x10..0x13
        base = 19'h10; wlast = 19'h13; iter = 2; vld = 1'b1; ready = 1'b1; auto_ret = 1'b1;
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 4; i++) exp_q.push_back(AW'(32'h10 + i));
        cnt_log.delete();
        done_pulses = 0;
        en = 1'b1;
        step(1);
        check("start_latency_valid", rif.rd_req_valid, 1);
        check("start_latency_addr", rif.rd_req_addr, 19'h10);
        wait_done(80);
        step(2);
        check("basic_done_pulses", done_pulses, 1);
        check("basic_state_done_busy", busy, 1);
        check("basic_valid_idle", rif.rd_req_valid, 0);
        check("basic_icnt", icnt, 2);
        check("basic_queue_empty", exp_q.size(), 0);
        check("basic_log_len", cnt_log.size(), 2);
        check("basic_log0", (cnt_log.size() > 0) ? cnt_log[0] : '1, 1);
        check("basic_log1", (cnt_log.size() > 1) ? cnt_log[1] : '1, 2);
        en = 1'b0;
        step(2);
        check("basic_idle_busy", busy, 0);
        check("basic_icnt_held", icnt, 2);

        // Credit limit: no returns, 8 requests max
        do_reset();
        base = 19'h20; wlast = 19'h3F; iter = 1; auto_ret = 1'b0; ready = 1'b1;
        for (int i = 0; i < 8; i++) exp_q.push_back(AW'(32'h20 + i));
        h0 = hs_cnt;
        en = 1'b1;
        step(20);
        check("credit_8_hs", hs_cnt - h0, 8);
        check("credit_full_valid", rif.rd_req_valid, 0);
        exp_q.push_back(19'h28);
        man_dv = 1'b1;
        step(1);
        man_dv = 1'b0;
        step(8);
        check("credit_one_more_hs", hs_cnt - h0, 9);
        check("credit_refull_valid", rif.rd_req_valid, 0);
        check("credit_queue_empty", exp_q.size(), 0);
        do_reset();

        // Stall with abort
        base = 19'h40; wlast = 19'h47; iter = 3; ready = 1'b0; auto_ret = 1'b1;
        exp_q.push_back(19'h40);
        h0 = hs_cnt;
        en = 1'b1;
        step(1);
        for (int i = 0; i < 5; i++) begin
            check("stall_valid", rif.rd_req_valid, 1);
            check("stall_addr", rif.rd_req_addr, 19'h40);
            if (i == 2) en = 1'b0;
            step(1);
        end
        ready = 1'b1;
        step(1);
        check("abort_valid_drop", rif.rd_req_valid, 0);
        check("abort_drain_busy", busy, 1);
        for (int n = 0; n < 10 && busy; n++) step(1);
        check("abort_idle", busy, 0);
        step(5);
        check("abort_one_hs", hs_cnt - h0, 1);
        check("abort_icnt", icnt, 0);
        check("abort_cerr", cerr, 0);

        // Config error and stray return
        do_reset();
        base = 19'h10; wlast = 19'h05; vld = 1'b1;
        h0 = hs_cnt;
        en = 1'b1;
        step(3);
        check("cfg_err_set", cerr, 1);
        check("cfg_err_busy", busy, 0);
        check("cfg_err_no_req", hs_cnt - h0, 0);
        do_reset();
        check("cfg_err_cleared", cerr, 0);
        man_dv = 1'b1;
        step(1);
        man_dv = 1'b0;
        step(1);
        check("stray_ret_err", cerr, 1);
        do_reset();

        // Loop forever over a single word, then reset mid-run
        base = 19'h7; wlast = 19'h7; iter = 0; ready = 1'b1; auto_ret = 1'b1;
        for (int i = 0; i < 40; i++) exp_q.push_back(19'h7);
        done_pulses = 0;
        h0 = hs_cnt;
        en = 1'b1;
        step(30);
        check("forever_hs_min", 64'((hs_cnt - h0) >= 8), 1);
        check("forever_icnt_min", 64'(icnt >= 7), 1);
        check("forever_no_done", done_pulses, 0);
        rst = 1'b1;
        step(1);
        check("midrst_valid", rif.rd_req_valid, 0);
        check("midrst_addr", rif.rd_req_addr, 0);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_icnt", icnt, 0);
        check("midrst_cerr", cerr, 0);
        step(2);
        en = 1'b0;
        rst = 1'b0;
        step(3);
        check("midrst_no_err", cerr, 0);
        exp_q.delete();

`ifdef PCAP_REPLAY_IPG_EN
        // Inter-iteration gap of 3 cycles
        do_reset();
        gap = 3; base = 19'h50; wlast = 19'h51; iter = 2; ready = 1'b1; auto_ret = 1'b1;
        for (int k = 0; k < 2; k++) begin
            exp_q.push_back(19'h50);
            exp_q.push_back(19'h51);
        end
        rets = 0; t_ret = -1; t_req = -1; done_pulses = 0;
        en = 1'b1;
        wait_done(80);
        check("gap_idle_cycles", t_req - t_ret - 1, 3);
        check("gap_icnt", icnt, 2);
        check("gap_queue_empty", exp_q.size(), 0);
        do_reset();
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
